// File: rtl/tx_pkg.sv
// Shared types and constants for the QPSK transmit path.
// Sample levels are +/-1/sqrt2 in Q1.11.
package tx_pkg;

  localparam int SAMPLE_W = 12;
  localparam logic [SAMPLE_W-1:0] AMP_POS = 12'h5A7;
  localparam logic [SAMPLE_W-1:0] AMP_NEG = 12'hA59;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] i;
    logic signed [SAMPLE_W-1:0] q;
  } iq_sample_t;

  // The default amplitude folds to the precomputed negative level.
  function automatic logic [SAMPLE_W-1:0] map_bit(input logic b, input logic [SAMPLE_W-1:0] amp);
    if (b) return amp;
    return (amp == AMP_POS) ? AMP_NEG : -amp;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry valid/ready register stage: output register plus one skid entry.
// s_ready is registered and depends only on skid occupancy; full rate when m_ready stays high.
module axis_skid_buf #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic         out_vld_q, out_vld_d;
  logic [W-1:0] out_dat_q, out_dat_d;
  logic         sk_vld_q, sk_vld_d;
  logic [W-1:0] sk_dat_q, sk_dat_d;
  logic         rdy_q, rdy_d;
  logic         push, out_free;

  always_comb begin
    push      = s_valid & rdy_q;
    out_free  = !out_vld_q | m_ready;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    sk_vld_d  = sk_vld_q;
    sk_dat_d  = sk_dat_q;
    if (out_free) begin
      if (sk_vld_q) begin
        out_vld_d = 1'b1;
        out_dat_d = sk_dat_q;
        sk_vld_d  = push;
        if (push) sk_dat_d = s_data;
      end else begin
        // Empty path: the new value goes straight to the output register.
        out_vld_d = push;
        if (push) out_dat_d = s_data;
      end
    end else if (push) begin
      sk_vld_d = 1'b1;
      sk_dat_d = s_data;
    end
    rdy_d = !sk_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      sk_vld_q  <= 1'b0;
      sk_dat_q  <= '0;
      rdy_q     <= 1'b0;
    end else begin
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      sk_vld_q  <= sk_vld_d;
      sk_dat_q  <= sk_dat_d;
      rdy_q     <= rdy_d;
    end
  end

  assign s_ready = rdy_q;
  assign m_valid = out_vld_q;
  assign m_data  = out_dat_q;

endmodule

// File: rtl/tx_path_qpsk.sv
// QPSK mapper front end: one (I,Q) symbol in, one registered 12-bit I/Q pair out via a 2-entry skid.
// TX_BYTE_INPUT_EN selects a byte input serialized MSB-first into 4 symbols.
module tx_path_qpsk #(
  parameter int                       SAMPLE_W = tx_pkg::SAMPLE_W,
  parameter logic [SAMPLE_W-1:0]      AMP      = tx_pkg::AMP_POS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_I,
  input  logic                  in_Q,
  input  logic [7:0]            in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*SAMPLE_W-1:0] out_data
);
  import tx_pkg::*;

  logic       s_valid, s_ready;
  logic       sym_i, sym_q;
  iq_sample_t s_dat;

`ifdef TX_BYTE_INPUT_EN
  logic       ser_vld_q, ser_vld_d;
  logic [1:0] ser_cnt_q, ser_cnt_d;
  logic [7:0] ser_dat_q, ser_dat_d;
  logic       en_q;
  logic       sym_push, byte_acc;
  logic       unused_bits;

  assign unused_bits = in_I ^ in_Q;
  assign sym_push    = ser_vld_q & s_ready;
  // A new byte may land in the same cycle the last symbol leaves.
  assign in_ready    = en_q & (!ser_vld_q | ((ser_cnt_q == 2'd3) & s_ready));
  assign byte_acc    = in_valid & in_ready;

  always_comb begin
    ser_vld_d = ser_vld_q;
    ser_cnt_d = ser_cnt_q;
    ser_dat_d = ser_dat_q;
    if (byte_acc) begin
      ser_vld_d = 1'b1;
      ser_cnt_d = 2'd0;
      ser_dat_d = in_data;
    end else if (sym_push) begin
      ser_dat_d = {ser_dat_q[5:0], 2'b00};
      ser_cnt_d = ser_cnt_q + 2'd1;
      if (ser_cnt_q == 2'd3) ser_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ser_vld_q <= 1'b0;
      ser_cnt_q <= 2'd0;
      ser_dat_q <= 8'd0;
      en_q      <= 1'b0;
    end else begin
      ser_vld_q <= ser_vld_d;
      ser_cnt_q <= ser_cnt_d;
      ser_dat_q <= ser_dat_d;
      en_q      <= 1'b1;
    end
  end

  assign s_valid = ser_vld_q;
  assign sym_i   = ser_dat_q[7];
  assign sym_q   = ser_dat_q[6];
`else
  logic unused_in_data;

  assign unused_in_data = ^in_data;
  assign s_valid        = in_valid;
  assign in_ready       = s_ready;
  assign sym_i          = in_I;
  assign sym_q          = in_Q;
`endif

  always_comb begin
    s_dat.i = map_bit(sym_i, AMP);
    s_dat.q = map_bit(sym_q, AMP);
  end

  axis_skid_buf #(.W($bits(iq_sample_t))) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_dat),
    .m_valid (out_valid),
    .m_ready (out_ready),
    .m_data  (out_data)
  );

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && in_valid) begin
`ifdef TX_BYTE_INPUT_EN
      assert (!$isunknown(in_data)) else $error("tx_path_qpsk: X on in_data while in_valid");
`else
      assert (!$isunknown({in_I, in_Q})) else $error("tx_path_qpsk: X on in_I/in_Q while in_valid");
`endif
    end
  end
`endif

endmodule

// File: tb/tb_tx_path_qpsk.sv
// Directed and random bench for tx_path_qpsk; model is a queue of expected I/Q pairs.
// Define TX_BYTE_INPUT_EN to exercise the byte-input build.
module tb_tx_path_qpsk;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_I, in_Q, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid;
  logic [23:0] out_data;

  int          nvec = 0, nerr = 0;
  logic [23:0] exp_q[$];
  logic        stalled = 1'b0;
  logic [23:0] held = '0;

`ifdef TX_BYTE_INPUT_EN
  localparam int N_RAND = 250;
`else
  localparam int N_RAND = 1000;
`endif

  always #5 clk = ~clk;

  tx_path_qpsk dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_I      (in_I),
    .in_Q      (in_Q),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  function automatic logic [11:0] lvl(input logic b);
    return b ? 12'(1447) : 12'(-1447);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_empty", 32'(exp_q.size()), 0);
  endtask

  // Scoreboard: handshakes are evaluated mid-cycle, before the edge that completes them.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_vld", out_valid, 1);
        chk("hold_dat", out_data, held);
      end
      if (out_valid && out_ready) begin
        chk("pop_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("order_dat", out_data, exp_q.pop_front());
        chk("legal_i", (out_data[23:12] == 12'h5A7) || (out_data[23:12] == 12'hA59), 1);
        chk("legal_q", (out_data[11:0] == 12'h5A7) || (out_data[11:0] == 12'hA59), 1);
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (in_valid && in_ready) begin
`ifdef TX_BYTE_INPUT_EN
        for (int k = 0; k < 4; k++)
          exp_q.push_back({lvl(in_data[7-2*k]), lvl(in_data[6-2*k])});
`else
        exp_q.push_back({lvl(in_I), lvl(in_Q)});
`endif
      end
    end
  end

  initial begin
    logic [1:0]  sym  [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
    logic [23:0] dexp [4] = '{24'h5A75A7, 24'h5A7A59, 24'hA595A7, 24'hA59A59};
    logic [23:0] bexp [4] = '{24'h5A7A59, 24'h5A75A7, 24'hA595A7, 24'hA59A59};
    logic [23:0] first;
    int acc, cyc;

    rst = 1'b1; in_valid = 1'b0; in_I = 1'b0; in_Q = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (64) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

`ifdef TX_BYTE_INPUT_EN
    in_valid = 1'b1; in_data = 8'hB4;
    @(posedge clk); #1;
    chk("byte_lat", out_valid, 0);
    chk("byte_busy", in_ready, 0);
    in_data = 8'h00;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("byte_vld", out_valid, 1);
      chk("byte_dat", out_data, bexp[k]);
      if (k < 3) chk("byte_rdy", in_ready, k == 2);
    end
    in_valid = 1'b0;
    drain();
`else
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; {in_I, in_Q} = sym[k]; in_data = 8'($urandom);
      @(posedge clk); #1;
      chk("dir_vld", out_valid, 1);
      chk("dir_dat", out_data, dexp[k]);
      chk("dir_rdy", in_ready, 1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("dir_idle", out_valid, 0);

    out_ready = 1'b0; acc = 0; first = '0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_I = 1'($urandom); in_Q = 1'($urandom);
      if (in_ready) acc++;
      @(posedge clk); #1;
      if (c == 0) first = out_data;
    end
    chk("bp_accepts", acc, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_hold", out_data, first);
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
`endif

    acc = 0; cyc = 0;
    while (acc < N_RAND && cyc < 20000) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_I      = 1'($urandom_range(0, 1));
      in_Q      = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_count", acc, N_RAND);
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_I = 1'($urandom); in_Q = 1'($urandom); in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_rst_vld", out_valid, 1);
    chk("pre_rst_full", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_vld", out_valid, 0);
    rst = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("no_stale", out_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
